// File: rtl/pattern_gen_pkg.sv
// rtl/pattern_gen_pkg.sv - shared types and constants for the pattern generator
// Playback FSM states and the pattern buffer read latency.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_RUN   = 2'd1,
    PG_DRAIN = 2'd2
  } pg_state_t;

  localparam int PG_RD_LATENCY = 2;

endpackage

// File: rtl/MemoryMacro.sv
// rtl/MemoryMacro.sv - dual-port RAM macro with optional registered read stages
// Port A writes; port B reads (and writes only in true dual-port builds).
module MemoryMacro #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter int TRUE_DUAL    = 0,
  parameter int PORTA_WRONLY = 1,
  parameter int USE_BLOCK    = 1,
  parameter int OUT_REG      = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk_a,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] din_a,
  input  logic             clk_b,
  input  logic             en_b,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] din_b,
  output logic [WIDTH-1:0] dout_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data;

  if (TRUE_DUAL == 0 && PORTA_WRONLY != 0) begin : g_sdp
    always_ff @(posedge clk_a) begin
      if (we_a) mem[addr_a] <= din_a;
    end
  end else begin : g_tdp
    always_ff @(posedge clk_a) begin
      if (we_a) mem[addr_a] <= din_a;
    end
    always_ff @(posedge clk_b) begin
      if (en_b && we_b) mem[addr_b] <= din_b;
    end
  end

  // Block RAM reads are synchronous; reads see the pre-write word on collision.
  if (USE_BLOCK != 0) begin : g_block
    logic [WIDTH-1:0] rd_q;
    always_ff @(posedge clk_b) begin
      if (en_b) rd_q <= mem[addr_b];
    end
    assign rd_data = rd_q;
  end else begin : g_dist
    assign rd_data = mem[addr_b];
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] out_q;
    always_ff @(posedge clk_b) begin
      out_q <= rd_data;
    end
    assign dout_b = out_q;
  end else begin : g_nooreg
    assign dout_b = rd_data;
  end

endmodule

// File: rtl/pattern_generator.sv
// rtl/pattern_generator.sv - block-RAM pattern playback onto a 32-bit transmit bus
// One-shot or looped playback with a trigger strobe tagged at read issue.
module pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int unsigned BUF_SIZE  = 32'h8000,
  localparam int unsigned ADDR_BITS = $clog2(BUF_SIZE)
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic                 buf_wr_en,
  input  logic [ADDR_BITS-1:0] buf_wr_addr,
  input  logic [31:0]          buf_wr_data,
  input  logic [ADDR_BITS:0]   cfg_length,
  input  logic [ADDR_BITS-1:0] cfg_trigger_pos,
  input  logic                 cfg_loop,
  input  logic                 start,
  input  logic                 stop,
  output logic [31:0]          tx_data,
  output logic                 tx_valid,
  output logic                 tx_trigger,
  output logic                 busy,
  output logic                 done
);

  localparam int DRAIN_W = (PG_RD_LATENCY > 1) ? $clog2(PG_RD_LATENCY) : 1;

  pg_state_t state_q, state_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_BITS:0]   len_q, len_d;
  logic [ADDR_BITS-1:0] trig_q, trig_d;
  logic                 loop_q, loop_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [PG_RD_LATENCY-1:0] vld_q, vld_d;
  logic [PG_RD_LATENCY-1:0] tag_q, tag_d;
  logic                 done_q, done_d;
  logic                 issue, last, clear_pipe;
  logic [31:0]          ram_dout;

  assign issue = (state_q == PG_RUN);
  // Compare on ADDR_BITS+1 bits so a full-depth pass ends at BUF_SIZE-1.
  assign last  = ({1'b0, rd_addr_q} == (len_q - {{ADDR_BITS{1'b0}}, 1'b1}));

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    len_d      = len_q;
    trig_d     = trig_q;
    loop_d     = loop_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    clear_pipe = 1'b0;
    unique case (state_q)
      PG_IDLE: begin
        if (!stop && start && (cfg_length != '0)) begin
          len_d     = cfg_length;
          trig_d    = cfg_trigger_pos;
          loop_d    = cfg_loop;
          rd_addr_d = '0;
          state_d   = PG_RUN;
        end
      end
      PG_RUN: begin
        if (stop) begin
          state_d    = PG_IDLE;
          clear_pipe = 1'b1;
        end else if (last) begin
          rd_addr_d = '0;
          if (!loop_q) begin
            state_d = PG_DRAIN;
            drain_d = '0;
          end
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      PG_DRAIN: begin
        if (stop) begin
          state_d    = PG_IDLE;
          clear_pipe = 1'b1;
        end else if (drain_q == DRAIN_W'(PG_RD_LATENCY - 1)) begin
          state_d = PG_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = PG_IDLE;
    endcase
  end

  always_comb begin
    vld_d = '0;
    tag_d = '0;
    if (!clear_pipe) begin
      vld_d = {vld_q[PG_RD_LATENCY-2:0], issue};
      tag_d = {tag_q[PG_RD_LATENCY-2:0], issue && (rd_addr_q == trig_q)};
    end
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q   <= PG_IDLE;
      rd_addr_q <= '0;
      len_q     <= '0;
      trig_q    <= '0;
      loop_q    <= 1'b0;
      drain_q   <= '0;
      vld_q     <= '0;
      tag_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      len_q     <= len_d;
      trig_q    <= trig_d;
      loop_q    <= loop_d;
      drain_q   <= drain_d;
      vld_q     <= vld_d;
      tag_q     <= tag_d;
      done_q    <= done_d;
    end
  end

  MemoryMacro #(
    .WIDTH       (32),
    .DEPTH       (BUF_SIZE),
    .TRUE_DUAL   (0),
    .PORTA_WRONLY(1),
    .USE_BLOCK   (1),
    .OUT_REG     (1)
  ) u_buf (
    .clk_a  (tx_clk),
    .we_a   (buf_wr_en),
    .addr_a (buf_wr_addr),
    .din_a  (buf_wr_data),
    .clk_b  (tx_clk),
    .en_b   (issue),
    .we_b   (1'b0),
    .addr_b (rd_addr_q),
    .din_b  (32'd0),
    .dout_b (ram_dout)
  );

  // RAM output registers are not reset, so gate data with the valid tag.
  assign tx_valid   = vld_q[PG_RD_LATENCY-1];
  assign tx_trigger = tag_q[PG_RD_LATENCY-1];
  assign tx_data    = tx_valid ? ram_dout : 32'd0;
  assign busy       = (state_q != PG_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_pattern_generator.sv
// tb/tb_pattern_generator.sv - self-checking bench for pattern_generator
module tb_pattern_generator;

  localparam int BS = 16;
  localparam int AB = 4;

  logic          tx_clk = 1'b0;
  logic          tx_rst;
  logic          buf_wr_en;
  logic [AB-1:0] buf_wr_addr;
  logic [31:0]   buf_wr_data;
  logic [AB:0]   cfg_length;
  logic [AB-1:0] cfg_trigger_pos;
  logic          cfg_loop;
  logic          start;
  logic          stop;
  logic [31:0]   tx_data;
  logic          tx_valid;
  logic          tx_trigger;
  logic          busy;
  logic          done;

  always #5 tx_clk = ~tx_clk;

  pattern_generator #(.BUF_SIZE(BS)) dut (
    .tx_clk          (tx_clk),
    .tx_rst          (tx_rst),
    .buf_wr_en       (buf_wr_en),
    .buf_wr_addr     (buf_wr_addr),
    .buf_wr_data     (buf_wr_data),
    .cfg_length      (cfg_length),
    .cfg_trigger_pos (cfg_trigger_pos),
    .cfg_loop        (cfg_loop),
    .start           (start),
    .stop            (stop),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_trigger      (tx_trigger),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic        v;
    logic [31:0] d;
    logic        t;
    logic        b;
    logic        dn;
  } vec_t;

  vec_t tbl [16];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] word(input int i);
    return 32'h5A00_0000 | (32'(i) << 16) | (32'hFFFF & ~32'(i));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge tx_clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [31:0] d,
                            input logic t, input logic b, input logic dn);
    check({tag, " valid"}, {31'd0, tx_valid}, {31'd0, v});
    check({tag, " data"}, tx_data, d);
    check({tag, " trigger"}, {31'd0, tx_trigger}, {31'd0, t});
    check({tag, " busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, " done"}, {31'd0, done}, {31'd0, dn});
  endtask

  task automatic run_table(input string tag);
    cfg_length = 5'd4; cfg_trigger_pos = 4'd2; cfg_loop = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_outs($sformatf("%s c%0d", tag, k), tbl[k].v, tbl[k].d, tbl[k].t, tbl[k].b, tbl[k].dn);
      start = tbl[k].start;
      stop  = tbl[k].stop;
      tick();
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int ntrig;
    // One-shot L=4 trig=2 with a start while busy (c4) and a back-to-back start (c7).
    tbl[0]  = '{1, 0, 0, 32'd0,   0, 0, 0};
    tbl[1]  = '{0, 0, 0, 32'd0,   0, 1, 0};
    tbl[2]  = '{0, 0, 0, 32'd0,   0, 1, 0};
    tbl[3]  = '{0, 0, 1, word(0), 0, 1, 0};
    tbl[4]  = '{1, 0, 1, word(1), 0, 1, 0};
    tbl[5]  = '{0, 0, 1, word(2), 1, 1, 0};
    tbl[6]  = '{0, 0, 1, word(3), 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 32'd0,   0, 0, 1};
    tbl[8]  = '{0, 0, 0, 32'd0,   0, 1, 0};
    tbl[9]  = '{0, 0, 0, 32'd0,   0, 1, 0};
    tbl[10] = '{0, 0, 1, word(0), 0, 1, 0};
    tbl[11] = '{0, 0, 1, word(1), 0, 1, 0};
    tbl[12] = '{0, 0, 1, word(2), 1, 1, 0};
    tbl[13] = '{0, 0, 1, word(3), 0, 1, 0};
    tbl[14] = '{0, 0, 0, 32'd0,   0, 0, 1};
    tbl[15] = '{0, 0, 0, 32'd0,   0, 0, 0};

    tx_rst = 1'b1; buf_wr_en = 1'b0; buf_wr_addr = '0; buf_wr_data = '0;
    cfg_length = '0; cfg_trigger_pos = '0; cfg_loop = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    tx_rst = 1'b0;
    check_outs("reset", 0, 32'd0, 0, 0, 0);

    for (int i = 0; i < BS; i++) begin
      buf_wr_en = 1'b1; buf_wr_addr = AB'(i); buf_wr_data = word(i);
      tick();
    end
    buf_wr_en = 1'b0;
    tick();

    run_table("oneshot");

    // Loop L=3 trig=1, stop sampled in cycle 10.
    cfg_length = 5'd3; cfg_trigger_pos = 4'd1; cfg_loop = 1'b1;
    ntrig = 0;
    for (int c = 0; c < 15; c++) begin
      if (c >= 3 && c <= 10) begin
        check_outs($sformatf("loop c%0d", c), 1, word((c - 3) % 3), ((c - 3) % 3) == 1, 1, 0);
        if (tx_trigger) ntrig++;
      end else if (c >= 1 && c <= 2) begin
        check_outs($sformatf("loop c%0d", c), 0, 32'd0, 0, 1, 0);
      end else begin
        check_outs($sformatf("loop c%0d", c), 0, 32'd0, 0, 0, 0);
      end
      start = (c == 0);
      stop  = (c == 10);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    check("loop trigger count", 32'(ntrig), 32'd3);

    // Full depth pass.
    cfg_length = 5'(BS); cfg_trigger_pos = 4'(BS - 1); cfg_loop = 1'b0;
    for (int c = 0; c < BS + 6; c++) begin
      if (c >= 3 && c <= BS + 2)
        check_outs($sformatf("full c%0d", c), 1, word(c - 3), c == BS + 2, 1, 0);
      else
        check_outs($sformatf("full c%0d", c), 0, 32'd0, 0, c >= 1 && c <= BS + 2, c == BS + 3);
      start = (c == 0);
      tick();
    end
    start = 1'b0;

    // Zero length start and start+stop from idle.
    cfg_length = 5'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check($sformatf("len0 busy c%0d", c), {31'd0, busy}, 32'd0);
      tick();
    end
    cfg_length = 5'd4;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check($sformatf("startstop busy c%0d", c), {31'd0, busy}, 32'd0);
      check($sformatf("startstop valid c%0d", c), {31'd0, tx_valid}, 32'd0);
      tick();
    end

    // Trigger position beyond the pass length.
    cfg_length = 5'd4; cfg_trigger_pos = 4'd5; cfg_loop = 1'b0;
    ntrig = 0;
    for (int c = 0; c < 9; c++) begin
      if (tx_trigger) ntrig++;
      if (c == 7) check("oor done", {31'd0, done}, 32'd1);
      start = (c == 0);
      tick();
    end
    start = 1'b0;
    check("oor trigger count", 32'(ntrig), 32'd0);

    // Reset mid-run in loop mode, then replay.
    cfg_length = 5'd4; cfg_trigger_pos = 4'd2; cfg_loop = 1'b1;
    for (int c = 0; c < 5; c++) begin
      start = (c == 0);
      tx_rst = (c == 4);
      tick();
    end
    start = 1'b0; tx_rst = 1'b0;
    check_outs("rst c5", 0, 32'd0, 0, 0, 0);
    for (int c = 6; c < 10; c++) begin
      check($sformatf("rst done c%0d", c), {31'd0, done}, 32'd0);
      check($sformatf("rst busy c%0d", c), {31'd0, busy}, 32'd0);
      tick();
    end

    run_table("replay");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
